instruction_prefetch_unit: RTL and testbench

//  Parametrised fetch front-end: prefetches sequential instruction words over the memory bus.

---
 rtl/ifetch_pkg.sv | 16 +
 rtl/ifetch_fifo.sv | 61 ++++++
 rtl/instruction_prefetch_unit.sv | 135 +++++++++++++
 tb/tb_instruction_prefetch_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
// FSM encoding is visible on state_o, so the values below are part of the interface.
package ifetch_pkg;

    localparam int IFETCH_STATE_W = 3;
    localparam int PC_INC         = 4;

    typedef enum logic [IFETCH_STATE_W-1:0] {
        INIT  = 3'd0,
        IDLE  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        FLUSH = 3'd4
    } state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: DEPTH-entry circular queue of {pc, instr} with flush.
// Latency: a push is visible at the head on the next cycle; head is read straight from registered storage.
// Backpressure: none internally; the caller reserves a slot before pushing. Pop on empty is ignored.
module ifetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [W-1:0]           i_push_dat,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [W-1:0]           o_head_dat
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_dat;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

endmodule

// File: rtl/instruction_prefetch_unit.sv
// Fetch front-end: sequential single-outstanding bus reads queued with PCs, handed to decode on valid/ready.
// Latency: first instruction valid after the 4th rising edge post-reset on a zero-wait bus; 1 word per 2 cycles.
// Backpressure: fetch idles while the buffer is full; bus_busy_i holds the request. IFETCH_ALIGN_CHK_EN traps misaligned redirects.
module instruction_prefetch_unit
    import ifetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_i,
    input  logic [ADDR_W-1:0]         redirect_pc_i,
    input  logic                      instr_ready_i,
    output logic                      instr_valid_o,
    output logic [DATA_W-1:0]         instr_o,
    output logic [ADDR_W-1:0]         instr_pc_o,
    output logic                      bus_read_o,
    output logic [ADDR_W-1:0]         bus_adr_o,
    input  logic                      bus_busy_i,
    input  logic                      bus_ack_i,
    input  logic [DATA_W-1:0]         bus_data_i,
    output logic [IFETCH_STATE_W-1:0] state_o,
    output logic                      fetch_err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  DEPTH_M1   = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDR_W-1:0]          r_fetch_pc;
    logic [ADDR_W-1:0]          w_fetch_pc_nxt;
    logic [ADDR_W-1:0]          w_redir_pc;
    logic [CNT_W-1:0]           w_count;
    logic [ADDR_W+DATA_W-1:0]   w_head;
    logic                       w_redir;
    logic                       w_valid;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_full;
    logic                       w_room_after_push;
    logic                       w_err;

    // Redirect is ignored in INIT so the first cycle after reset always starts clean.
    assign w_redir = redirect_i && (r_state != INIT);

`ifdef IFETCH_ALIGN_CHK_EN
    logic r_err;

    assign w_redir_pc = redirect_pc_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_redir) begin
            r_err <= (redirect_pc_i[1:0] != 2'b00);
        end
    end

    assign w_err = r_err;
`else
    assign w_redir_pc = redirect_pc_i & ALIGN_MASK;
    assign w_err      = 1'b0;
`endif

    assign w_valid = (w_count != '0);
    assign w_pop   = w_valid && instr_ready_i && !w_redir;
    assign w_push  = (r_state == WAIT) && bus_ack_i && !w_redir;
    assign w_full  = (w_count == DEPTH_CNT);
    // After this push, is there still a free slot to reserve for the next read?
    assign w_room_after_push = (w_count < DEPTH_M1) || w_pop;

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        case (r_state)
            INIT: w_state_nxt = IDLE;
            IDLE: begin
                if (!w_redir && !w_full && !w_err) w_state_nxt = REQ;
            end
            REQ: begin
                if (w_redir)          w_state_nxt = bus_busy_i ? IDLE : FLUSH;
                else if (!bus_busy_i) w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_redir)        w_state_nxt = bus_ack_i ? IDLE : FLUSH;
                else if (bus_ack_i) w_state_nxt = w_room_after_push ? REQ : IDLE;
            end
            FLUSH: begin
                if (bus_ack_i) w_state_nxt = IDLE;
            end
            default: w_state_nxt = INIT;
        endcase
        if (w_redir)     w_fetch_pc_nxt = w_redir_pc;
        else if (w_push) w_fetch_pc_nxt = r_fetch_pc + PC_STEP;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= INIT;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_push_dat ({r_fetch_pc, bus_data_i}),
        .i_pop      (w_pop),
        .i_flush    (w_redir),
        .o_count    (w_count),
        .o_head_dat (w_head)
    );

    assign instr_valid_o             = w_valid;
    assign {instr_pc_o, instr_o}     = w_head;
    assign bus_read_o                = (r_state == REQ);
    assign bus_adr_o                 = (r_state == REQ) ? r_fetch_pc : '0;
    assign state_o                   = r_state;
    assign fetch_err_o               = w_err;

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Bench for instruction_prefetch_unit: queue-based model of the buffer and a bus responder with random waits.
module tb_instruction_prefetch_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        instr_ready_i = 1'b0;
    logic        bus_busy_i = 1'b0;
    logic        bus_ack_i = 1'b0;
    logic [31:0] bus_data_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        bus_read_o;
    logic [31:0] bus_adr_o;
    logic [2:0]  state_o;
    logic        fetch_err_o;

    instruction_prefetch_unit #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)
    ) dut (
        .clk(clk), .rst(rst),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_ready_i(instr_ready_i), .instr_valid_o(instr_valid_o),
        .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .bus_read_o(bus_read_o), .bus_adr_o(bus_adr_o),
        .bus_busy_i(bus_busy_i), .bus_ack_i(bus_ack_i), .bus_data_i(bus_data_i),
        .state_o(state_o), .fetch_err_o(fetch_err_o)
    );

    always #5 clk = ~clk;

    // Reference model: buffer contents as a queue, plus the one outstanding bus read.
    logic [31:0] q_pc[$];
    logic [31:0] q_dat[$];
    bit          pend = 0;
    bit          pend_stale = 0;
    int          pend_dly = 0;
    logic [31:0] pend_adr = '0;
    logic [31:0] last_acc_adr = '0;
    int          cfg_dly_min = 0;
    int          cfg_dly_max = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Advance one clock: entered and left at a falling edge.
    task automatic tick();
        bit          acc;
        bit          pop;
        bit          redir;
        logic [31:0] acc_adr;
        bus_ack_i  = pend && (pend_dly == 0);
        bus_data_i = bus_ack_i ? memf(pend_adr) : $urandom;
        acc     = bus_read_o && !bus_busy_i;
        acc_adr = bus_adr_o;
        pop     = (q_pc.size() != 0) && instr_ready_i;
        redir   = redirect_i;
        @(posedge clk);
        #1;
        if (pop && !redir) begin
            void'(q_pc.pop_front());
            void'(q_dat.pop_front());
        end
        if (bus_ack_i) begin
            if (!pend_stale && !redir) begin
                q_pc.push_back(pend_adr);
                q_dat.push_back(memf(pend_adr));
            end
            pend = 0;
        end else if (pend) begin
            pend_dly--;
        end
        if (redir) begin
            q_pc.delete();
            q_dat.delete();
            if (pend) pend_stale = 1;
        end
        if (acc) begin
            pend         = 1;
            pend_adr     = acc_adr;
            pend_stale   = redir;
            pend_dly     = $urandom_range(cfg_dly_max, cfg_dly_min);
            last_acc_adr = acc_adr;
            acc_cnt++;
        end
        redirect_i = 1'b0;
        bus_ack_i  = 1'b0;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [101:0] v;
        rst = 1'b0;
        instr_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        v = {state_o, instr_valid_o, instr_o, instr_pc_o, bus_read_o, bus_adr_o, fetch_err_o};
        checks++;
        if (v !== '0) begin failures++; $display("FAIL reset_outputs got=%h want=0", v); end
        rst = 1'b1;
        cyc = 0;
        checks++;
        if (state_o !== 3'd0) begin failures++; $display("FAIL reset_init got=%0d want=0", state_o); end
        tick();
        checks++;
        if (state_o !== 3'd1) begin failures++; $display("FAIL reset_idle got=%0d want=1", state_o); end
        tick();
        checks++;
        if (state_o !== 3'd2 || bus_read_o !== 1'b1 || bus_adr_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_req state=%0d rd=%0b adr=%h want 2/1/0", state_o, bus_read_o, bus_adr_o);
        end
    endtask

    task automatic test_stream();
        logic [31:0] pcs[$];
        int          cycs[$];
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (instr_valid_o !== (q_pc.size() != 0)) begin
                failures++; $display("FAIL stream_valid got=%0b want=%0b", instr_valid_o, q_pc.size() != 0);
            end else if (instr_valid_o) begin
                checks++;
                if (instr_pc_o !== q_pc[0] || instr_o !== q_dat[0]) begin
                    failures++;
                    $display("FAIL stream_head got=%h/%h want=%h/%h", instr_pc_o, instr_o, q_pc[0], q_dat[0]);
                end
                pcs.push_back(instr_pc_o);
                cycs.push_back(cyc);
            end
            tick();
        end
        checks++;
        if (pcs.size() < 4) begin
            failures++; $display("FAIL stream_count got=%0d want>=4", pcs.size());
        end else begin
            checks++;
            if (cycs[0] != 4) begin failures++; $display("FAIL stream_first_cycle got=%0d want=4", cycs[0]); end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (pcs[i] !== 32'(4 * i)) begin
                    failures++; $display("FAIL stream_pc%0d got=%h want=%h", i, pcs[i], 32'(4 * i));
                end
                if (i > 0) begin
                    checks++;
                    if (cycs[i] - cycs[i-1] != 2) begin
                        failures++; $display("FAIL stream_rate%0d got=%0d want=2", i, cycs[i] - cycs[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int a;
        instr_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        a = acc_cnt;
        repeat (40) tick();
        checks++;
        if (acc_cnt - a != DEPTH) begin failures++; $display("FAIL bp_reads got=%0d want=%0d", acc_cnt - a, DEPTH); end
        checks++;
        if (state_o !== 3'd1 || bus_read_o !== 1'b0) begin
            failures++; $display("FAIL bp_idle state=%0d rd=%0b want 1/0", state_o, bus_read_o);
        end
        checks++;
        if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h40 || instr_o !== memf(32'h40)) begin
            failures++; $display("FAIL bp_head got=%0b/%h want=1/40", instr_valid_o, instr_pc_o);
        end
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        a = acc_cnt;
        repeat (8) tick();
        checks++;
        if (acc_cnt - a != 1 || last_acc_adr !== 32'h50) begin
            failures++; $display("FAIL bp_refill reads=%0d adr=%h want 1/50", acc_cnt - a, last_acc_adr);
        end
        checks++;
        if (instr_pc_o !== 32'h44) begin failures++; $display("FAIL bp_pop got=%h want=44", instr_pc_o); end
    endtask

    task automatic test_busy();
        int n;
        int a;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h80;
        tick();
        n = 0;
        while (!bus_read_o && n < 10) begin tick(); n++; end
        checks++;
        if (!bus_read_o) begin failures++; $display("FAIL busy_wait_req got=0 want=1"); end
        bus_busy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus_busy_i = 1'b0;
            checks++;
            if (bus_read_o !== 1'b1 || bus_adr_o !== 32'h80) begin
                failures++; $display("FAIL busy_hold%0d rd=%0b adr=%h want 1/80", i, bus_read_o, bus_adr_o);
            end
            a = acc_cnt;
            tick();
        end
        checks++;
        if (acc_cnt != a + 1 || state_o !== 3'd3) begin
            failures++; $display("FAIL busy_accept acc=%0d state=%0d want 1/3", acc_cnt - a, state_o);
        end
    endtask

    task automatic test_redirect_flush();
        int n;
        bit got_req;
        bit got_val;
        instr_ready_i = 1'b1;
        cfg_dly_min = 2;
        cfg_dly_max = 2;
        n = 0;
        while (!(state_o == 3'd3 && pend && pend_dly == 2) && n < 20) begin tick(); n++; end
        checks++;
        if (!(state_o == 3'd3 && pend && pend_dly == 2)) begin
            failures++; $display("FAIL redir_wait_state got=%0d want=3", state_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h100;
        tick();
        cfg_dly_min = 0;
        cfg_dly_max = 0;
        checks++;
        if (state_o !== 3'd4 || instr_valid_o !== 1'b0) begin
            failures++; $display("FAIL redir_flush state=%0d vld=%0b want 4/0", state_o, instr_valid_o);
        end
        got_req = 0;
        got_val = 0;
        for (int i = 0; i < 20 && !(got_req && got_val); i++) begin
            if (!got_req && bus_read_o && !bus_busy_i) begin
                got_req = 1;
                checks++;
                if (bus_adr_o !== 32'h100) begin failures++; $display("FAIL redir_adr got=%h want=100", bus_adr_o); end
            end
            if (!got_val && instr_valid_o) begin
                got_val = 1;
                checks++;
                if (instr_pc_o !== 32'h100 || instr_o !== memf(32'h100)) begin
                    failures++; $display("FAIL redir_head got=%h/%h want=100/%h", instr_pc_o, instr_o, memf(32'h100));
                end
            end
            tick();
        end
        checks++;
        if (!(got_req && got_val)) begin failures++; $display("FAIL redir_timeout req=%0b val=%0b want 1/1", got_req, got_val); end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [101:0] v;
        instr_ready_i = 1'b0;
        cfg_dly_min = 3;
        cfg_dly_max = 3;
        n = 0;
        while (state_o != 3'd3 && n < 20) begin tick(); n++; end
        checks++;
        if (state_o !== 3'd3) begin failures++; $display("FAIL rstmid_wait got=%0d want=3", state_o); end
        #2;
        rst = 1'b0;
        #1;
        v = {state_o, instr_valid_o, instr_o, instr_pc_o, bus_read_o, bus_adr_o, fetch_err_o};
        checks++;
        if (v !== '0) begin failures++; $display("FAIL rstmid_outputs got=%h want=0", v); end
        q_pc.delete();
        q_dat.delete();
        pend = 0;
        cfg_dly_min = 0;
        cfg_dly_max = 0;
        @(negedge clk);
        rst = 1'b1;
        // Late acks arriving in INIT and IDLE must be ignored.
        for (int i = 0; i < 2; i++) begin
            pend = 1; pend_stale = 1; pend_dly = 0; pend_adr = 32'hDEAD_0000;
            tick();
        end
        checks++;
        if (state_o !== 3'd2 || instr_valid_o !== 1'b0 || bus_adr_o !== 32'h0) begin
            failures++;
            $display("FAIL rstmid_restart state=%0d vld=%0b adr=%h want 2/0/0", state_o, instr_valid_o, bus_adr_o);
        end
    endtask

    task automatic test_align();
        int n;
        instr_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
`ifdef IFETCH_ALIGN_CHK_EN
        checks++;
        if (fetch_err_o !== 1'b1) begin failures++; $display("FAIL align_err_set got=%0b want=1", fetch_err_o); end
        n = acc_cnt;
        repeat (8) begin
            checks++;
            if (bus_read_o !== 1'b0) begin failures++; $display("FAIL align_halt rd=%0b want=0", bus_read_o); end
            tick();
        end
        checks++;
        if (acc_cnt != n || fetch_err_o !== 1'b1) begin
            failures++; $display("FAIL align_sticky reads=%0d err=%0b want 0/1", acc_cnt - n, fetch_err_o);
        end
        redirect_i = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        checks++;
        if (fetch_err_o !== 1'b0) begin failures++; $display("FAIL align_err_clr got=%0b want=0", fetch_err_o); end
        n = 0;
        while (!bus_read_o && n < 10) begin tick(); n++; end
        checks++;
        if (bus_read_o !== 1'b1 || bus_adr_o !== 32'h200) begin
            failures++; $display("FAIL align_resume rd=%0b adr=%h want 1/200", bus_read_o, bus_adr_o);
        end
`else
        checks++;
        if (fetch_err_o !== 1'b0) begin failures++; $display("FAIL align_err_tied got=%0b want=0", fetch_err_o); end
        n = 0;
        while (!bus_read_o && n < 10) begin tick(); n++; end
        checks++;
        if (bus_read_o !== 1'b1 || bus_adr_o !== 32'h100) begin
            failures++; $display("FAIL align_force rd=%0b adr=%h want 1/100", bus_read_o, bus_adr_o);
        end
`endif
    endtask

    task automatic test_random();
        logic [31:0] exp_adr;
        logic [31:0] tgt;
        logic [31:0] prev_adr;
        bit          prev_hold;
        cfg_dly_min = 0;
        cfg_dly_max = 3;
        redirect_i = 1'b1;
        redirect_pc_i = 32'h400;
        exp_adr = 32'h400;
        bus_busy_i = 1'b0;
        tick();
        prev_hold = 0;
        prev_adr = '0;
        for (int i = 0; i < 800; i++) begin
            bus_busy_i    = ($urandom_range(0, 3) == 0);
            instr_ready_i = ($urandom_range(0, 9) < 6);
`ifdef IFETCH_ALIGN_CHK_EN
            tgt = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
`else
            tgt = {22'h0, 10'($urandom_range(0, 1023))};
`endif
            redirect_i    = ($urandom_range(0, 31) == 0);
            redirect_pc_i = tgt;
            checks++;
            if (instr_valid_o !== (q_pc.size() != 0)) begin
                failures++; $display("FAIL rnd_valid i=%0d got=%0b want=%0b", i, instr_valid_o, q_pc.size() != 0);
            end else if (instr_valid_o) begin
                checks++;
                if (instr_pc_o !== q_pc[0] || instr_o !== q_dat[0]) begin
                    failures++;
                    $display("FAIL rnd_head i=%0d got=%h/%h want=%h/%h", i, instr_pc_o, instr_o, q_pc[0], q_dat[0]);
                end
            end
            if (prev_hold) begin
                checks++;
                if (bus_read_o !== 1'b1 || bus_adr_o !== prev_adr) begin
                    failures++; $display("FAIL rnd_hold i=%0d rd=%0b adr=%h want 1/%h", i, bus_read_o, bus_adr_o, prev_adr);
                end
            end
            if (bus_read_o && !bus_busy_i) begin
                checks++;
                if (bus_adr_o !== exp_adr) begin
                    failures++; $display("FAIL rnd_req_adr i=%0d got=%h want=%h", i, bus_adr_o, exp_adr);
                end
                exp_adr = exp_adr + 32'd4;
            end
            if (redirect_i) exp_adr = tgt & ~32'h3;
            prev_hold = bus_read_o && bus_busy_i && !redirect_i;
            prev_adr  = bus_adr_o;
            tick();
        end
        bus_busy_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_busy();
        test_redirect_flush();
        test_reset_mid();
        test_align();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
